// File: rtl/regfile_pkg.sv
// Shared constants and types for the multiport register file.
// Default geometry lives here so the top and bench agree on it.
package regfile_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_NUM_RD   = 3;
  localparam int RF_NUM_WR   = 2;
  localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);

  typedef logic [RF_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending-producer bit per register.
// Ports: i_clk, i_rst (sync, active-high), i_clr write mask,
//        i_alloc_en/i_alloc_addr set request, o_busy busy vector.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_REGS-1:0] i_clr,
  input  logic                i_alloc_en,
  input  logic [ADDR_W-1:0]   i_alloc_addr,
  output logic [NUM_REGS-1:0] o_busy
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set;

  // Register 0 can never be allocated.
  always_comb begin
    w_set = '0;
    if (i_alloc_en && i_alloc_addr != '0)
      w_set[i_alloc_addr] = 1'b1;
  end

  // Set after clear: alloc+write on one reg leaves it busy.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_busy <= '0;
    else
      r_busy <= (r_busy & ~i_clr) | w_set;
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/multiport_regfile.sv
// Multiport register file with write-port priority and scoreboard.
// Ports: CLK, RESET (sync, active-high); rd_addr/rd_data/rd_busy
//        per read port; wr_en/wr_addr/wr_data per write port;
//        alloc_en/alloc_addr mark a pending producer; wr_collide
//        flags a same-register multi-write in the previous cycle.
// Build option: REGFILE_BYPASS_EN forwards same-cycle writes to reads.
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int NUM_WR   = RF_NUM_WR
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  output logic                     wr_collide
);

  logic [ADDR_W-1:0]   w_wa [NUM_WR];
  logic [DATA_W-1:0]   w_wd [NUM_WR];
  logic [ADDR_W-1:0]   w_ra [NUM_RD];
  logic [NUM_REGS-1:0] w_we;
  logic [DATA_W-1:0]   w_wdata [NUM_REGS];
  logic [NUM_REGS-1:0] w_busy;
  logic                w_collide;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic                r_collide;

  genvar g;
  for (g = 0; g < NUM_WR; g++) begin : g_wr
    assign w_wa[g] = wr_addr[g*ADDR_W +: ADDR_W];
    assign w_wd[g] = wr_data[g*DATA_W +: DATA_W];
  end

  for (g = 0; g < NUM_RD; g++) begin : g_rd
    assign w_ra[g] = rd_addr[g*ADDR_W +: ADDR_W];
  end

  // Ascending scan: the highest enabled port lands last and wins.
  // Writes are dropped during reset and never reach register 0.
  always_comb begin
    w_we = '0;
    for (int r = 0; r < NUM_REGS; r++)
      w_wdata[r] = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en[p] && !RESET && w_wa[p] != '0) begin
        w_we[w_wa[p]]    = 1'b1;
        w_wdata[w_wa[p]] = w_wd[p];
      end
    end
  end

  always_comb begin
    w_collide = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (wr_en[i] && wr_en[j] &&
            w_wa[i] == w_wa[j] && w_wa[i] != '0)
          w_collide = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int r = 0; r < NUM_REGS; r++)
        r_regs[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        if (w_we[r])
          r_regs[r] <= w_wdata[r];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      r_collide <= 1'b0;
    else
      r_collide <= w_collide;
  end

  assign wr_collide = r_collide;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_sb (
    .i_clk        (CLK),
    .i_rst        (RESET),
    .i_clr        (w_we),
    .i_alloc_en   (alloc_en),
    .i_alloc_addr (alloc_addr),
    .o_busy       (w_busy)
  );

  // w_we[0] is never set, so forwarding cannot touch register 0.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data[i*DATA_W +: DATA_W] = r_regs[w_ra[i]];
      rd_busy[i]                  = w_busy[w_ra[i]];
`ifdef REGFILE_BYPASS_EN
      if (w_we[w_ra[i]]) begin
        rd_data[i*DATA_W +: DATA_W] = w_wdata[w_ra[i]];
        rd_busy[i] = alloc_en && (alloc_addr == w_ra[i]);
      end
`endif
    end
  end

endmodule
